// File: rtl/cc_line_fill_unit_p.sv
// Line fill engine: pops one miss, gathers BEATS wrapped R beats into a line, writes it once; wren_o one cycle after last beat.
// Backpressure: R stalled outside FILL, write held until wr_ready_i. CC_FILL_CRIT_BYPASS_EN adds a critical-beat bypass.
module cc_line_fill_unit_p #(
    parameter int DATA_W     = 64,
    parameter int LINE_BYTES = 64,
    parameter int INDEX_W    = 9,
    parameter int ADDR_W     = 32,
    localparam int LINE_W    = LINE_BYTES * 8,
    localparam int BEATS     = LINE_W / DATA_W,
    localparam int OFF_W     = $clog2(LINE_BYTES),
    localparam int BSEL_W    = $clog2(BEATS),
    localparam int TAG_W     = ADDR_W - INDEX_W - OFF_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [DATA_W-1:0]  mem_rdata_i,
    input  logic               mem_rlast_i,
    input  logic               mem_rvalid_i,
    output logic               mem_rready_o,
    input  logic               miss_addr_fifo_empty_i,
    input  logic [ADDR_W-1:0]  miss_addr_fifo_rdata_i,
    output logic               miss_addr_fifo_rden_o,
    output logic               wren_o,
    input  logic               wr_ready_i,
    output logic [INDEX_W-1:0] waddr_o,
    output logic [TAG_W:0]     wdata_tag_o,
    output logic [LINE_W-1:0]  wdata_data_o,
    output logic               busy_o,
    output logic               rlast_err_o
`ifdef CC_FILL_CRIT_BYPASS_EN
    ,
    output logic               crit_valid_o,
    output logic [DATA_W-1:0]  crit_data_o,
    output logic [INDEX_W-1:0] crit_index_o
`endif
);

    typedef enum logic [1:0] {IDLE, FILL, WRITE} state_t;

    localparam logic [BSEL_W:0] LAST_CNT = (BSEL_W + 1)'(BEATS - 1);

    state_t              state;
    logic [BSEL_W:0]     cnt;
    logic [BSEL_W-1:0]   start_q;
    logic [BSEL_W-1:0]   slot;
    logic                early_last;
    logic                fill_beat;
    logic                pop;

    assign fill_beat = mem_rready_o && mem_rvalid_i;
    assign slot      = start_q + cnt[BSEL_W-1:0];
    // Show-ahead FIFO: the pop is decided combinationally in the same cycle the head is latched.
    assign pop = !rst && !miss_addr_fifo_empty_i &&
                 ((state == IDLE) || (state == WRITE && wren_o && wr_ready_i));
    assign miss_addr_fifo_rden_o = pop;

    generate
        if (OFF_W > BSEL_W) begin : g_low_bits
            logic unused_addr_bits;
            assign unused_addr_bits = ^miss_addr_fifo_rdata_i[OFF_W-BSEL_W-1:0];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            start_q      <= '0;
            early_last   <= 1'b0;
            mem_rready_o <= 1'b0;
            wren_o       <= 1'b0;
            busy_o       <= 1'b0;
            rlast_err_o  <= 1'b0;
            waddr_o      <= '0;
            wdata_tag_o  <= '0;
            wdata_data_o <= '0;
`ifdef CC_FILL_CRIT_BYPASS_EN
            crit_valid_o <= 1'b0;
            crit_data_o  <= '0;
            crit_index_o <= '0;
`endif
        end else begin
            rlast_err_o <= 1'b0;
`ifdef CC_FILL_CRIT_BYPASS_EN
            crit_valid_o <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (pop) begin
                        state        <= FILL;
                        mem_rready_o <= 1'b1;
                        busy_o       <= 1'b1;
                    end
                end
                FILL: begin
                    if (fill_beat) begin
                        for (int k = 0; k < BEATS; k++) begin
                            if (slot == BSEL_W'(k))
                                wdata_data_o[k*DATA_W +: DATA_W] <= mem_rdata_i;
                        end
                        cnt <= cnt + 1'b1;
`ifdef CC_FILL_CRIT_BYPASS_EN
                        if (cnt == '0) begin
                            crit_valid_o <= 1'b1;
                            crit_data_o  <= mem_rdata_i;
                            crit_index_o <= waddr_o;
                        end
`endif
                        // A protocol error never shortens the fill; it is only reported.
                        if (cnt == LAST_CNT) begin
                            state        <= WRITE;
                            mem_rready_o <= 1'b0;
                            wren_o       <= 1'b1;
                            rlast_err_o  <= !mem_rlast_i || early_last;
                        end else if (mem_rlast_i) begin
                            early_last <= 1'b1;
                        end
                    end
                end
                WRITE: begin
                    if (wr_ready_i) begin
                        wren_o <= 1'b0;
                        if (pop) begin
                            state        <= FILL;
                            mem_rready_o <= 1'b1;
                        end else begin
                            state  <= IDLE;
                            busy_o <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase

            if (pop) begin
                waddr_o     <= miss_addr_fifo_rdata_i[OFF_W+INDEX_W-1:OFF_W];
                wdata_tag_o <= {1'b1, miss_addr_fifo_rdata_i[ADDR_W-1:OFF_W+INDEX_W]};
                start_q     <= miss_addr_fifo_rdata_i[OFF_W-1:OFF_W-BSEL_W];
                cnt         <= '0;
                early_last  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cc_line_fill_unit_p.sv
// Bench for cc_line_fill_unit_p: directed literal cases plus randomized traffic against a behavioural line-fill model.
module tb_cc_line_fill_unit_p;

    localparam int DATA_W     = 64;
    localparam int LINE_BYTES = 64;
    localparam int INDEX_W    = 9;
    localparam int ADDR_W     = 32;
    localparam int LINE_W     = LINE_BYTES * 8;
    localparam int BEATS      = LINE_W / DATA_W;
    localparam int TAG_W      = 17;

    typedef logic [LINE_W-1:0] wv_t;

    logic               clk = 1'b0;
    logic               rst;
    logic [DATA_W-1:0]  mem_rdata_i;
    logic               mem_rlast_i;
    logic               mem_rvalid_i;
    logic               mem_rready_o;
    logic               miss_addr_fifo_empty_i;
    logic [ADDR_W-1:0]  miss_addr_fifo_rdata_i;
    logic               miss_addr_fifo_rden_o;
    logic               wren_o;
    logic               wr_ready_i;
    logic [INDEX_W-1:0] waddr_o;
    logic [TAG_W:0]     wdata_tag_o;
    logic [LINE_W-1:0]  wdata_data_o;
    logic               busy_o;
    logic               rlast_err_o;
`ifdef CC_FILL_CRIT_BYPASS_EN
    logic               crit_valid_o;
    logic [DATA_W-1:0]  crit_data_o;
    logic [INDEX_W-1:0] crit_index_o;
    logic [DATA_W-1:0]  seen_cd = '0;
    logic [INDEX_W-1:0] seen_ci = '0;
`endif

    cc_line_fill_unit_p #(
        .DATA_W(DATA_W), .LINE_BYTES(LINE_BYTES), .INDEX_W(INDEX_W), .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk), .rst(rst),
        .mem_rdata_i(mem_rdata_i), .mem_rlast_i(mem_rlast_i),
        .mem_rvalid_i(mem_rvalid_i), .mem_rready_o(mem_rready_o),
        .miss_addr_fifo_empty_i(miss_addr_fifo_empty_i),
        .miss_addr_fifo_rdata_i(miss_addr_fifo_rdata_i),
        .miss_addr_fifo_rden_o(miss_addr_fifo_rden_o),
        .wren_o(wren_o), .wr_ready_i(wr_ready_i),
        .waddr_o(waddr_o), .wdata_tag_o(wdata_tag_o), .wdata_data_o(wdata_data_o),
        .busy_o(busy_o), .rlast_err_o(rlast_err_o)
`ifdef CC_FILL_CRIT_BYPASS_EN
        , .crit_valid_o(crit_valid_o), .crit_data_o(crit_data_o), .crit_index_o(crit_index_o)
`endif
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    function automatic void chk(input string name, input wv_t act, input wv_t exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // Stimulus knobs and the show-ahead miss FIFO owned by the bench.
    logic [ADDR_W-1:0] fifo_q[$];
    int  rv_pct = 0;
    int  wr_pct = 100;
    int  err_beat = -1;
    bit  dir_mode = 1'b1;
    bit  rand_err = 1'b0;
    bit  pop_pend = 1'b0;

    // Behavioural model: one miss at a time, beats land at (start + n) mod BEATS.
    bit                 m_fill = 0, m_wp = 0, m_early = 0, m_err = 0, after_rst = 0;
    int                 m_n = 0, m_s = 0;
    logic [INDEX_W-1:0] m_idx = '0;
    logic [TAG_W-1:0]   m_tag = '0;
    logic [LINE_W-1:0]  m_line = '0;
    bit                 m_cv = 0;
    logic [DATA_W-1:0]  m_cd = '0;
    logic [INDEX_W-1:0] m_ci = '0;

    always @(negedge clk) begin
        bit exp_rden;
        bit busy_m;
        int slot;
        logic [ADDR_W-1:0] a;
        busy_m = m_fill || m_wp;
        if (after_rst) begin
            chk("rst_waddr", wv_t'(waddr_o), '0);
            chk("rst_tag", wv_t'(wdata_tag_o), '0);
            chk("rst_data", wdata_data_o, '0);
        end
        chk("busy", wv_t'(busy_o), wv_t'(busy_m));
        chk("rready", wv_t'(mem_rready_o), wv_t'(m_fill));
        chk("wren", wv_t'(wren_o), wv_t'(m_wp));
        if (m_wp) begin
            chk("waddr", wv_t'(waddr_o), wv_t'(m_idx));
            chk("wtag", wv_t'(wdata_tag_o), wv_t'({1'b1, m_tag}));
            chk("wdata", wdata_data_o, m_line);
        end
        chk("rlast_err", wv_t'(rlast_err_o), wv_t'(m_err));
`ifdef CC_FILL_CRIT_BYPASS_EN
        chk("crit_valid", wv_t'(crit_valid_o), wv_t'(m_cv));
        if (m_cv) begin
            chk("crit_data", wv_t'(crit_data_o), wv_t'(m_cd));
            chk("crit_index", wv_t'(crit_index_o), wv_t'(m_ci));
        end
        if (crit_valid_o) begin
            seen_cd = crit_data_o;
            seen_ci = crit_index_o;
        end
`endif
        exp_rden = !rst && !miss_addr_fifo_empty_i && (!busy_m || (m_wp && wr_ready_i));
        chk("rden", wv_t'(miss_addr_fifo_rden_o), wv_t'(exp_rden));
        pop_pend = miss_addr_fifo_rden_o && !miss_addr_fifo_empty_i;

        m_err = 0;
        m_cv  = 0;
        if (rst) begin
            m_fill = 0; m_wp = 0; m_n = 0; after_rst = 1;
        end else begin
            after_rst = 0;
            if (m_fill && mem_rvalid_i) begin
                slot = (m_s + m_n) % BEATS;
                m_line[slot*DATA_W +: DATA_W] = mem_rdata_i;
                if (m_n == 0) begin
                    m_cv = 1; m_cd = mem_rdata_i; m_ci = m_idx;
                end
                if (m_n < BEATS - 1 && mem_rlast_i) m_early = 1;
                m_n++;
                if (m_n == BEATS) begin
                    m_err  = !mem_rlast_i || m_early;
                    m_fill = 0;
                    m_wp   = 1;
                end
            end else if (m_wp && wr_ready_i) begin
                m_wp = 0;
            end
            if (exp_rden) begin
                a       = miss_addr_fifo_rdata_i;
                m_idx   = INDEX_W'((a / LINE_BYTES) % (1 << INDEX_W));
                m_tag   = TAG_W'(a / (LINE_BYTES * (1 << INDEX_W)));
                m_s     = int'((a % LINE_BYTES) / (DATA_W / 8));
                m_n     = 0;
                m_early = 0;
                m_fill  = 1;
            end
        end
    end

    // Input driver: updates every input just after the rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (pop_pend) begin
                void'(fifo_q.pop_front());
                pop_pend = 0;
            end
            mem_rvalid_i = ($urandom_range(1, 100) <= rv_pct);
            if (dir_mode) mem_rdata_i = 64'hA0 + 64'(m_n);
            else          mem_rdata_i = {$urandom, $urandom};
            mem_rlast_i = (m_n == BEATS - 1) || (m_n == err_beat);
            if (rand_err && $urandom_range(0, 29) == 0) mem_rlast_i = !mem_rlast_i;
            wr_ready_i = ($urandom_range(1, 100) <= wr_pct);
            miss_addr_fifo_empty_i = (fifo_q.size() == 0);
            miss_addr_fifo_rdata_i = (fifo_q.size() == 0) ? '0 : fifo_q[0];
        end
    end

    task automatic push(input logic [ADDR_W-1:0] a);
        fifo_q.push_back(a);
    endtask

    task automatic wait_wren(input string name);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (wren_o) break;
        end
        chk({name, "_wren_seen"}, wv_t'(wren_o), wv_t'(1));
    endtask

    task automatic wait_rden(input string name);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (miss_addr_fifo_rden_o) break;
        end
        chk({name, "_rden_seen"}, wv_t'(miss_addr_fifo_rden_o), wv_t'(1));
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (!busy_o && !wren_o && fifo_q.size() == 0) break;
        end
        chk({name, "_idle"}, wv_t'(busy_o), '0);
    endtask

    logic [LINE_W-1:0] line_aligned, line_wrap;
    int n;

    initial begin
        rst = 1'b1;
        mem_rdata_i = '0; mem_rlast_i = 1'b0; mem_rvalid_i = 1'b0; wr_ready_i = 1'b1;
        miss_addr_fifo_empty_i = 1'b1; miss_addr_fifo_rdata_i = '0;
        line_aligned = {64'hA7, 64'hA6, 64'hA5, 64'hA4, 64'hA3, 64'hA2, 64'hA1, 64'hA0};
        line_wrap    = {64'hA2, 64'hA1, 64'hA0, 64'hA7, 64'hA6, 64'hA5, 64'hA4, 64'hA3};
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_busy", wv_t'(busy_o), '0);
        chk("reset_wren", wv_t'(wren_o), '0);
        chk("reset_rready", wv_t'(mem_rready_o), '0);
        chk("reset_data", wdata_data_o, '0);

        // Aligned fill
        rv_pct = 100;
        push(32'h0000_1F40);
        wait_wren("t1");
        chk("t1_waddr", wv_t'(waddr_o), wv_t'(9'h07D));
        chk("t1_tag", wv_t'(wdata_tag_o), wv_t'(18'h20000));
        chk("t1_data", wdata_data_o, line_aligned);
        wait_idle("t1");

        // Critical-word-first wrap, start beat 5
        push(32'h0000_1F68);
        wait_wren("t2");
        chk("t2_data", wdata_data_o, line_wrap);
        chk("t2_no_err", wv_t'(rlast_err_o), '0);
`ifdef CC_FILL_CRIT_BYPASS_EN
        chk("t2_crit_data", wv_t'(seen_cd), wv_t'(64'hA0));
        chk("t2_crit_index", wv_t'(seen_ci), wv_t'(9'h07D));
`endif
        wait_idle("t2");

        // SRAM backpressure: wr_ready low for the first four write cycles
        wr_pct = 0;
        push(32'h0000_2A80);
        wait_wren("t3");
        n = 0;
        for (int i = 0; i < 20; i++) begin
            if (!wren_o) break;
            n++;
            if (n == 4) wr_pct = 100;
            @(negedge clk);
        end
        chk("t3_hold_cycles", wv_t'(n), wv_t'(5));
        wait_idle("t3");

        // Two queued misses: no idle bubble between them
        push(32'h0000_0040);
        push(32'h0001_0078);
        wait_rden("t4");
        n = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!busy_o) break;
            n++;
        end
        chk("t4_busy_run", wv_t'(n), wv_t'(18));
        wait_idle("t4");

        // Early RLAST on the third beat
        err_beat = 2;
        push(32'h0000_1F40);
        wait_wren("t5");
        chk("t5_err_pulse", wv_t'(rlast_err_o), wv_t'(1));
        chk("t5_data", wdata_data_o, line_aligned);
        wait_idle("t5");
        err_beat = -1;

        // Reset in the middle of a fill, then a clean fill
        push(32'h0000_3FC0);
        wait_rden("t6");
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("t6_busy", wv_t'(busy_o), '0);
        chk("t6_rready", wv_t'(mem_rready_o), '0);
        push(32'h0000_1F68);
        wait_wren("t6b");
        chk("t6_data", wdata_data_o, line_wrap);
        wait_idle("t6");

        // Randomized traffic
        dir_mode = 1'b0;
        rand_err = 1'b1;
        for (int c = 0; c < 4000; c++) begin
            @(posedge clk);
            #1;
            if (c % 50 == 0) begin
                rv_pct = int'($urandom_range(30, 100));
                wr_pct = int'($urandom_range(20, 100));
            end
            if (fifo_q.size() < 3 && $urandom_range(0, 7) == 0) push($urandom);
            rst = ($urandom_range(0, 399) == 0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        rand_err = 1'b0;
        rv_pct = 100;
        wr_pct = 100;
        wait_idle("drain");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
